// File: rtl/universal_shift_register_if.sv
// -----------------------------------------------------------------------------
// universal_shift_register_if
//   Bundles the control, data and status signals of universal_shift_register.
//   master : the sequencer / controller driving the register
//   slave  : the register itself
//
//   sync_clear      synchronous clear request
//   mode[2:0]       operation select
//   start           request a WORD_LENGTH-shift burst with the current mode
//   parallel_in     load data
//   serial_in_lsb   bit entering bit 0 on shift left
//   serial_in_msb   bit entering the MSB on logical shift right
//   data_out        register contents
//   serial_out_msb  data_out MSB
//   serial_out_lsb  data_out LSB
//   busy            burst in progress
//   done            one-cycle pulse when a burst completes
// -----------------------------------------------------------------------------
interface universal_shift_register_if #(
  parameter int WORD_LENGTH = 6
);
  logic                   sync_clear;
  logic [2:0]             mode;
  logic                   start;
  logic [WORD_LENGTH-1:0] parallel_in;
  logic                   serial_in_lsb;
  logic                   serial_in_msb;
  logic [WORD_LENGTH-1:0] data_out;
  logic                   serial_out_msb;
  logic                   serial_out_lsb;
  logic                   busy;
  logic                   done;

  modport master (
    output sync_clear, mode, start, parallel_in, serial_in_lsb, serial_in_msb,
    input  data_out, serial_out_msb, serial_out_lsb, busy, done
  );

  modport slave (
    input  sync_clear, mode, start, parallel_in, serial_in_lsb, serial_in_msb,
    output data_out, serial_out_msb, serial_out_lsb, busy, done
  );
endinterface

// File: rtl/universal_shift_register.sv
// -----------------------------------------------------------------------------
// universal_shift_register
//   WORD_LENGTH-bit register with hold, parallel load, logical / arithmetic
//   shifts, rotates and synchronous clear. A start request with a shift or
//   rotate mode launches a burst that applies exactly WORD_LENGTH shifts of
//   the latched mode, so serial sequencers need not count cycles.
//
//   clk    rising-edge clock
//   reset  asynchronous, active-low; clears all state
//   bus    universal_shift_register_if.slave (control, data and status)
// -----------------------------------------------------------------------------
module universal_shift_register #(
  parameter int WORD_LENGTH = 6
) (
  input  logic                          clk,
  input  logic                          reset,
  universal_shift_register_if.slave     bus
);

  localparam int CNT_W = $clog2(WORD_LENGTH + 1);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;

  localparam logic [CNT_W-1:0]       CNT_FULL  = CNT_W'(WORD_LENGTH);
  localparam logic [CNT_W-1:0]       CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]       CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [WORD_LENGTH-1:0] WORD_ZERO = {WORD_LENGTH{1'b0}};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t                 state_r, state_next_s;
  logic [WORD_LENGTH-1:0] data_r, data_next_s;
  logic [CNT_W-1:0]       count_r, count_next_s;
  logic [2:0]             burst_mode_r, burst_mode_next_s;
  logic                   done_r, done_next_s;

  // Next register value for one mode operation; hold and the reserved
  // encoding both keep the current contents.
  function automatic logic [WORD_LENGTH-1:0] apply_mode(
    input logic [2:0]             op,
    input logic [WORD_LENGTH-1:0] cur,
    input logic [WORD_LENGTH-1:0] load_val,
    input logic                   sil,
    input logic                   sim
  );
    logic [WORD_LENGTH-1:0] res;
    case (op)
      MODE_HOLD: res = cur;
      MODE_LOAD: res = load_val;
      MODE_SHL:  res = {cur[WORD_LENGTH-2:0], sil};
      MODE_SHR:  res = {sim, cur[WORD_LENGTH-1:1]};
      MODE_ROL:  res = {cur[WORD_LENGTH-2:0], cur[WORD_LENGTH-1]};
      MODE_ROR:  res = {cur[0], cur[WORD_LENGTH-1:1]};
      MODE_ASR:  res = {cur[WORD_LENGTH-1], cur[WORD_LENGTH-1:1]};
      default:   res = cur;
    endcase
    return res;
  endfunction

  // Only shift and rotate modes (010..110) may launch a burst.
  function automatic logic is_burst_mode(input logic [2:0] op);
    return (op >= MODE_SHL) && (op <= MODE_ASR);
  endfunction

  // Next-state logic: clear first, then an active burst, then the mode op.
  always_comb begin
    state_next_s      = state_r;
    data_next_s       = data_r;
    count_next_s      = count_r;
    burst_mode_next_s = burst_mode_r;
    done_next_s       = 1'b0;

    if (bus.sync_clear) begin
      // Clear aborts any burst without a done pulse.
      state_next_s = ST_IDLE;
      data_next_s  = WORD_ZERO;
      count_next_s = CNT_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start && is_burst_mode(bus.mode)) begin
            // Register holds on the accepting edge; shifts start next edge.
            state_next_s      = ST_SHIFT;
            burst_mode_next_s = bus.mode;
            count_next_s      = CNT_FULL;
          end else begin
            data_next_s = apply_mode(bus.mode, data_r, bus.parallel_in,
                                     bus.serial_in_lsb, bus.serial_in_msb);
          end
        end
        ST_SHIFT: begin
          data_next_s = apply_mode(burst_mode_r, data_r, data_r,
                                   bus.serial_in_lsb, bus.serial_in_msb);
          // The <= also catches a zero count, so the counter never wraps.
          if (count_r <= CNT_ONE) begin
            state_next_s = ST_IDLE;
            count_next_s = CNT_ZERO;
            done_next_s  = 1'b1;
          end else begin
            count_next_s = count_r - CNT_ONE;
          end
        end
        default: begin
          state_next_s = ST_IDLE;
          count_next_s = CNT_ZERO;
        end
      endcase
    end
  end

  // State, data, counter and done registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      data_r       <= WORD_ZERO;
      count_r      <= CNT_ZERO;
      burst_mode_r <= MODE_HOLD;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      data_r       <= data_next_s;
      count_r      <= count_next_s;
      burst_mode_r <= burst_mode_next_s;
      done_r       <= done_next_s;
    end
  end

  assign bus.data_out       = data_r;
  assign bus.serial_out_msb = data_r[WORD_LENGTH-1];
  assign bus.serial_out_lsb = data_r[0];
  assign bus.busy           = (state_r == ST_SHIFT);
  assign bus.done           = done_r;

endmodule
